imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Shares the single instruction memory port between two requesters: the CPU fetch stage and the debug/program-loader port. It grants at most one access per cycle with fetch priority and a bounded-starvation rule for debug. It translates word addresses into memory indices with range checking, and routes the one-cycle-later response back to the requester that issued it. It sits between the IF stage or debug unit and a synchronous-read instruction memory array.

## Interface
- `START_BYTE_ADDR`, default 32'h00003000: byte address of memory word 0; must be word-aligned.
- `DEPTH_WORDS`, default 1024: memory depth in words; power of two.
- `STARVE_LIMIT`, default 4: number of consecutive fetch wins after which a pending debug request must win; range 1..15.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `f_req_valid` in 1: fetch request.
- `f_req_ready` out 1: fetch granted this cycle.
- `f_addr` in 30: fetch word address [31:2].
- `f_resp_valid` out 1: fetch response valid.
- `f_resp_data` out 32: fetched instruction.
- `f_resp_err` out 1: address out of range.
- `d_req_valid` in 1: debug request.
- `d_req_ready` out 1: debug granted this cycle.
- `d_req_we` in 1: 1 = write, 0 = read.
- `d_addr` in 30: debug word address [31:2].
- `d_wdata` in 32: write data.
- `d_resp_valid` out 1: debug response valid.
- `d_resp_data` out 32: read data; 0 for writes.
- `d_resp_err` out 1: address out of range.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: memory write.
- `mem_index` out log2(DEPTH_WORDS): word index.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: read data, valid the cycle after `mem_en` with `mem_we`=0.

## Operation
- Handshake: a request transfers in a cycle where valid and ready are both 1. A requester holds valid and its payload stable until ready. Ready is combinational from valid and arbiter state.
- Arbitration, evaluated each cycle:
  - Only one valid: that requester is granted.
  - Both valid and `starve_cnt` < STARVE_LIMIT: fetch is granted and `starve_cnt` increments.
  - Both valid and `starve_cnt` == STARVE_LIMIT: debug is granted and `starve_cnt` clears.
  - Whenever `d_req_valid` is 0, or debug is granted, `starve_cnt` clears.
  - `starve_cnt` is 4 bits and saturates at STARVE_LIMIT.
- Address translation: `index = addr - START_BYTE_ADDR[31:2]`, computed as a 30-bit unsigned subtraction that wraps modulo 2^30. The address is in range iff `index < DEPTH_WORDS`, so addresses below the base wrap high and are rejected.
  - `mem_index` carries the low log2(DEPTH_WORDS) bits of `index`.
- Granted in-range access: `mem_en`=1. `mem_we` = `d_req_we` for debug and 0 for fetch. `mem_wdata` = `d_wdata`.
- Granted out-of-range access: the request is still accepted, `mem_en`=0, and no memory access occurs.
- Response: a registered tag holds the owner, the error flag and the write flag. Exactly one response is issued, on the owner's port, one cycle after the grant.
  - Read data comes from `mem_rdata`.
  - Error responses and write acknowledgements return data 0.
- Responses cannot be back-pressured; the requester must accept them.
- No grant in a cycle means no response in the next cycle.

## Timing
- Throughput is one access per cycle; response latency is exactly 1 cycle after the grant.
- Back-to-back grants to different requesters produce back-to-back responses on their respective ports.
- Reset asserted (low):
  - Registered state: `f_resp_valid`, `d_resp_valid`, both `*_resp_err`, both `*_resp_data` = 0; `starve_cnt` = 0; tag cleared.
  - Combinational outputs are forced while reset is low: `f_req_ready`, `d_req_ready`, `mem_en`, `mem_we` = 0.
- Reset mid-operation: an in-flight response is dropped and never issued after reset deasserts.
- The first grant can occur in the first cycle with reset high.
- A write followed by a read of the same index in the next cycle returns the new data; the memory is write-first.

## Structure
- Shared package `imem_pkg`: START_BYTE_ADDR, DEPTH_WORDS, the index width constant, and the owner encoding `OWNER_FETCH`=0 / `OWNER_DEBUG`=1. The instruction memory uses the same base and depth constants.
- One sub-module, `imem_range_check`: combinational 30-bit subtract plus range compare, producing index and in_range. It is instantiated once on the granted address after the request mux.

## Test plan
- Fetch only, `f_addr`=30'h00000C00 (byte 0x3000), memory word 0 = 32'h24080001 → `mem_en`=1, `mem_index`=0; next cycle `f_resp_valid`=1, data 32'h24080001, err 0.
- Both valid continuously, STARVE_LIMIT=4 → grant sequence F,F,F,F,D,F,F,F,F,D; each response lands on the correct port one cycle after its grant.
- Debug write 32'hDEADBEEF to byte 0x3FFC (index 1023), then fetch the same address next cycle → debug ack with data 0; fetch returns 32'hDEADBEEF.
- Fetch byte 0x2FFC (below base) and byte 0x4000 (index 1024) → `mem_en`=0, `f_resp_err`=1, data 0; `starve_cnt` unaffected by fetch-only errors.
- Assert reset low in the cycle after a grant → no response appears after release; all outputs read 0 during reset; the next request behaves normally.
- Debug valid with fetch idle for 3 cycles, then both valid → debug is granted while alone, then fetch wins STARVE_LIMIT times before debug wins again.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction memory and its port arbiter.
package imem_pkg;

  localparam logic [31:0] START_BYTE_ADDR = 32'h00003000;
  localparam int unsigned DEPTH_WORDS     = 1024;
  localparam int unsigned IDX_W           = $clog2(DEPTH_WORDS);

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DEBUG = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
    logic   we;
  } resp_tag_t;

endpackage

// File: rtl/imem_range_check.sv
// Word address to memory index translation with a wrap-around range check.
module imem_range_check #(
  parameter logic [29:0] BASE_WORD = '0,
  parameter int unsigned IDX_W     = 10
) (
  input  logic [29:0]      addr,
  output logic [IDX_W-1:0] index,
  output logic             in_range
);

  logic [29:0] offset;

  // Addresses below the base wrap to large offsets and fail the high-bit test.
  always_comb begin
    offset   = addr - BASE_WORD;
    index    = offset[IDX_W-1:0];
    in_range = (offset[29:IDX_W] == '0);
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one synchronous-read instruction memory port between fetch and debug,
// fetch first, with debug guaranteed a win after STARVE_LIMIT consecutive losses.
module imem_port_arbiter #(
  parameter logic [31:0] START_BYTE_ADDR = imem_pkg::START_BYTE_ADDR,
  parameter int unsigned DEPTH_WORDS     = imem_pkg::DEPTH_WORDS,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           f_req_valid,
  output logic                           f_req_ready,
  input  logic [29:0]                    f_addr,
  output logic                           f_resp_valid,
  output logic [31:0]                    f_resp_data,
  output logic                           f_resp_err,
  input  logic                           d_req_valid,
  output logic                           d_req_ready,
  input  logic                           d_req_we,
  input  logic [29:0]                    d_addr,
  input  logic [31:0]                    d_wdata,
  output logic                           d_resp_valid,
  output logic [31:0]                    d_resp_data,
  output logic                           d_resp_err,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_index,
  output logic [31:0]                    mem_wdata,
  input  logic [31:0]                    mem_rdata
);

  import imem_pkg::*;

  localparam int unsigned IW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASE_WORD = START_BYTE_ADDR[31:2];

  logic [3:0]    starve_cnt;
  resp_tag_t     tag;
  logic          grant_f;
  logic          grant_d;
  logic          granted;
  logic [29:0]   req_addr;
  logic [IW-1:0] idx;
  logic          in_range;
  logic [31:0]   resp_data;

  always_comb begin
    grant_d  = reset && d_req_valid && (!f_req_valid || starve_cnt >= 4'(STARVE_LIMIT));
    grant_f  = reset && f_req_valid && !grant_d;
    granted  = grant_f || grant_d;
    req_addr = grant_d ? d_addr : f_addr;
  end

  imem_range_check #(
    .BASE_WORD (BASE_WORD),
    .IDX_W     (IW)
  ) u_range_check (
    .addr     (req_addr),
    .index    (idx),
    .in_range (in_range)
  );

  always_comb begin
    f_req_ready = grant_f;
    d_req_ready = grant_d;
    mem_en      = granted && in_range;
    mem_we      = granted && in_range && grant_d && d_req_we;
    mem_index   = idx;
    mem_wdata   = d_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      tag        <= '0;
    end else begin
      if (!d_req_valid || grant_d) begin
        starve_cnt <= '0;
      end else if (grant_f && starve_cnt < 4'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      tag.valid <= granted;
      tag.owner <= grant_d ? OWNER_DEBUG : OWNER_FETCH;
      tag.err   <= !in_range;
      tag.we    <= grant_d && d_req_we;
    end
  end

  // Response data is taken straight from the memory read port the cycle after the grant.
  always_comb begin
    resp_data    = (tag.err || tag.we) ? '0 : mem_rdata;
    f_resp_valid = tag.valid && (tag.owner == OWNER_FETCH);
    d_resp_valid = tag.valid && (tag.owner == OWNER_DEBUG);
    f_resp_err   = f_resp_valid && tag.err;
    d_resp_err   = d_resp_valid && tag.err;
    f_resp_data  = f_resp_valid ? resp_data : '0;
    d_resp_data  = d_resp_valid ? resp_data : '0;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized and directed bench for imem_port_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_imem_port_arbiter;

  localparam logic [29:0] BASE_W = 30'h00000C00;
  localparam int          LIMIT  = 4;
  localparam int          DEPTH  = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        f_req_valid = 1'b0;
  logic        f_req_ready;
  logic [29:0] f_addr = '0;
  logic        f_resp_valid;
  logic [31:0] f_resp_data;
  logic        f_resp_err;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic        d_req_we = 1'b0;
  logic [29:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        d_resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_index;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [31:0] env_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  bit          p_valid = 0, p_dbg = 0, p_err = 0;
  logic [31:0] p_data = '0;
  int          m_losses = 0;
  bit          log_en = 0;
  string       glog = "";
  bit          fire_f, fire_d;

  imem_port_arbiter #(
    .START_BYTE_ADDR (32'h00003000),
    .DEPTH_WORDS     (1024),
    .STARVE_LIMIT    (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .f_req_valid  (f_req_valid),
    .f_req_ready  (f_req_ready),
    .f_addr       (f_addr),
    .f_resp_valid (f_resp_valid),
    .f_resp_data  (f_resp_data),
    .f_resp_err   (f_resp_err),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_we     (d_req_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_resp_valid (d_resp_valid),
    .d_resp_data  (d_resp_data),
    .d_resp_err   (d_resp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_index    (mem_index),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory array the arbiter drives.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_index] = mem_wdata;
      else        mem_rdata <= env_mem[mem_index];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_log(input string name, input string exp);
    n_total++;
    if (glog == exp) n_pass++;
    else $display("FAIL %s: got %s expected %s", name, glog, exp);
  endtask

  // Transaction-level model: who wins, what the memory sees, what comes back next cycle.
  always @(negedge clock) begin : cmp
    bit          egf, egd, inr;
    logic [29:0] a, off;
    bit          fo, dob;
    if (!reset) begin
      chk("reset_ctl", {f_req_ready, d_req_ready, mem_en, mem_we,
                        f_resp_valid, d_resp_valid, f_resp_err, d_resp_err}, 0);
      chk("reset_data", {f_resp_data, d_resp_data}, 0);
      p_valid  = 0;
      m_losses = 0;
    end else begin
      egd = d_req_valid && (!f_req_valid || m_losses >= LIMIT);
      egf = f_req_valid && !egd;
      a   = egd ? d_addr : f_addr;
      off = a - BASE_W;
      inr = off < 30'(DEPTH);
      chk("ready", {f_req_ready, d_req_ready}, {egf, egd});
      chk("mem_en", mem_en, (egf || egd) && inr);
      chk("mem_we", mem_we, egd && inr && d_req_we);
      if ((egf || egd) && inr) chk("mem_index", mem_index, off[9:0]);
      if (egd && inr && d_req_we) chk("mem_wdata", mem_wdata, d_wdata);
      fo  = p_valid && !p_dbg;
      dob = p_valid && p_dbg;
      chk("f_resp", {f_resp_valid, f_resp_err, f_resp_data}, {fo, fo && p_err, fo ? p_data : 32'h0});
      chk("d_resp", {d_resp_valid, d_resp_err, d_resp_data}, {dob, dob && p_err, dob ? p_data : 32'h0});
      if (log_en) glog = {glog, f_req_ready ? "F" : (d_req_ready ? "D" : "-")};
      p_valid = egf || egd;
      p_dbg   = egd;
      p_err   = !inr;
      p_data  = (!inr || (egd && d_req_we)) ? 32'h0 : ref_mem[off[9:0]];
      if (egd && d_req_we && inr) ref_mem[off[9:0]] = d_wdata;
      if (!d_req_valid || egd) m_losses = 0;
      else if (egf)            m_losses++;
    end
  end

  task automatic set_in(input bit fv, input logic [29:0] fa, input bit dv, input bit dwe,
                        input logic [29:0] da, input logic [31:0] dwd);
    @(posedge clock); #1;
    f_req_valid = fv; f_addr = fa;
    d_req_valid = dv; d_req_we = dwe; d_addr = da; d_wdata = dwd;
  endtask

  function automatic logic [29:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return BASE_W - 30'd1;
      1:       return BASE_W + 30'd1024;
      2:       return 30'($urandom);
      default: return BASE_W + 30'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[0] = 32'h24080001;
    ref_mem[0] = 32'h24080001;

    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Plain fetch of word 0.
    set_in(1, 30'h00000C00, 0, 0, '0, '0);
    @(negedge clock);
    chk("t1_issue", {mem_en, mem_we, mem_index}, {1'b1, 1'b0, 10'd0});
    set_in(0, '0, 0, 0, '0, '0);
    @(negedge clock);
    chk("t1_resp", {f_resp_valid, f_resp_err, f_resp_data}, {1'b1, 1'b0, 32'h24080001});

    // Debug write to the last word, then fetch it back the next cycle.
    set_in(0, '0, 1, 1, 30'h00000FFF, 32'hDEADBEEF);
    @(negedge clock);
    chk("t3_write", {mem_en, mem_we, mem_index, mem_wdata}, {1'b1, 1'b1, 10'd1023, 32'hDEADBEEF});
    set_in(1, 30'h00000FFF, 0, 0, '0, '0);
    @(negedge clock);
    chk("t3_ack", {d_resp_valid, d_resp_err, d_resp_data}, {1'b1, 1'b0, 32'h0});
    set_in(0, '0, 0, 0, '0, '0);
    @(negedge clock);
    chk("t3_read", {f_resp_valid, f_resp_err, f_resp_data}, {1'b1, 1'b0, 32'hDEADBEEF});

    // Out-of-range fetches just below the base and one past the end.
    set_in(1, 30'h00000BFF, 0, 0, '0, '0);
    @(negedge clock);
    chk("t4_below_en", {f_req_ready, mem_en}, {1'b1, 1'b0});
    set_in(1, 30'h00001000, 0, 0, '0, '0);
    @(negedge clock);
    chk("t4_below_resp", {f_resp_valid, f_resp_err, f_resp_data}, {1'b1, 1'b1, 32'h0});
    chk("t4_end_en", {f_req_ready, mem_en}, {1'b1, 1'b0});
    set_in(0, '0, 0, 0, '0, '0);
    @(negedge clock);
    chk("t4_end_resp", {f_resp_valid, f_resp_err, f_resp_data}, {1'b1, 1'b1, 32'h0});

    // Continuous contention.
    set_in(1, BASE_W + 30'd5, 1, 0, BASE_W + 30'd7, '0);
    log_en = 1; glog = "";
    repeat (10) @(negedge clock);
    @(posedge clock); #1 log_en = 0;
    f_req_valid = 0; d_req_valid = 0;
    chk_log("grant_seq", "FFFFDFFFFD");

    // Debug alone for three cycles, then contention.
    set_in(0, '0, 1, 0, BASE_W + 30'd9, '0);
    log_en = 1; glog = "";
    repeat (3) @(negedge clock);
    set_in(1, BASE_W + 30'd2, 1, 0, BASE_W + 30'd9, '0);
    repeat (5) @(negedge clock);
    @(posedge clock); #1 log_en = 0;
    f_req_valid = 0; d_req_valid = 0;
    chk_log("debug_alone_seq", "DDDFFFFD");

    // Reset in the cycle after a grant drops the response.
    set_in(1, BASE_W + 30'd3, 0, 0, '0, '0);
    @(posedge clock); #1;
    reset = 0; f_req_valid = 1; d_req_valid = 1;
    @(negedge clock);
    chk("rst_forced", {f_req_ready, d_req_ready, mem_en, mem_we, f_resp_valid, d_resp_valid}, 0);
    @(posedge clock); #1;
    reset = 1; f_req_valid = 0; d_req_valid = 0;
    @(negedge clock);
    chk("rst_dropped", {f_resp_valid, d_resp_valid}, 0);
    set_in(1, 30'h00000C00, 0, 0, '0, '0);
    @(negedge clock);
    chk("rst_after_issue", {f_req_ready, mem_en, mem_index}, {1'b1, 1'b1, 10'd0});
    set_in(0, '0, 0, 0, '0, '0);
    @(negedge clock);
    chk("rst_after_resp", {f_resp_valid, f_resp_data}, {1'b1, 32'h24080001});

    // Random traffic with requesters holding until accepted and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      fire_f = f_req_valid && f_req_ready;
      fire_d = d_req_valid && d_req_ready;
      @(posedge clock); #1;
      if (!reset) reset = 1;
      else if ($urandom_range(0, 299) == 0) reset = 0;
      if (fire_f || !f_req_valid) begin
        f_req_valid = $urandom_range(0, 9) < 7;
        f_addr      = rnd_addr();
      end
      if (fire_d || !d_req_valid) begin
        d_req_valid = $urandom_range(0, 9) < 6;
        d_req_we    = $urandom_range(0, 1) == 1;
        d_addr      = rnd_addr();
        d_wdata     = $urandom;
      end
    end
    set_in(0, '0, 0, 0, '0, '0);
    repeat (2) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
